mem_arbiter: RTL

- Shares the single processor–memory port between the dcache and the icache.
- The dcache has default priority. A starvation counter guarantees that the icache eventually gets the port.
- Records which requester owns each outstanding load tag. Routes the transaction-tag acknowledge and the data-tag return only to the owning cache.
- Its icache_stall output drives the icache's dcache_request input.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache/memory port bundle shared by the dcache, icache and memory arbiter
interface mem_arbiter_if #(
    parameter int TAG_W = 4
) ();
    // Command encoding: 0 = MEM_NONE, 1 = MEM_LOAD, 2 = MEM_STORE
    logic [1:0]       dcache_command;
    logic [31:0]      dcache_addr;
    logic [63:0]      dcache_data;
    logic             icache_req;
    logic [1:0]       icache_command;
    logic [31:0]      icache_addr;
    logic [TAG_W-1:0] mem2proc_transaction_tag;
    logic [63:0]      mem2proc_data;
    logic [TAG_W-1:0] mem2proc_data_tag;

    logic [1:0]       proc2mem_command;
    logic [31:0]      proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic             icache_stall;
    logic             dcache_grant;
    logic [TAG_W-1:0] Dmem2proc_transaction_tag;
    logic [TAG_W-1:0] Imem2proc_transaction_tag;
    logic [TAG_W-1:0] Dmem2proc_data_tag;
    logic [TAG_W-1:0] Imem2proc_data_tag;
    logic [63:0]      mem2proc_data_out;
    logic             tag_error;

    modport master (
        output dcache_command, dcache_addr, dcache_data,
        output icache_req, icache_command, icache_addr,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  icache_stall, dcache_grant,
        input  Dmem2proc_transaction_tag, Imem2proc_transaction_tag,
        input  Dmem2proc_data_tag, Imem2proc_data_tag,
        input  mem2proc_data_out, tag_error
    );

    modport slave (
        input  dcache_command, dcache_addr, dcache_data,
        input  icache_req, icache_command, icache_addr,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output icache_stall, dcache_grant,
        output Dmem2proc_transaction_tag, Imem2proc_transaction_tag,
        output Dmem2proc_data_tag, Imem2proc_data_tag,
        output mem2proc_data_out, tag_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - dcache/icache arbiter for the single memory port with tag ownership routing
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int NUM_TAGS     = 16,
    parameter int TAG_W        = $clog2(NUM_TAGS)
) (
    input logic         clock,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    logic [7:0]          starve_cnt;
    logic [NUM_TAGS-1:1] owner_valid;
    logic [NUM_TAGS-1:1] owner_is_d;
    logic                tag_error_q;

    logic             force_i;
    logic             grant;
    logic             icache_sel;
    logic             ack_nonzero;
    logic             load_accept;
    logic             icache_accept;
    logic             ret_live;
    logic             ret_orphan;
    logic             reuse_live;
    logic [TAG_W-1:0] ack_tag;
    logic [TAG_W-1:0] ret_tag;

    assign ack_tag = bus.mem2proc_transaction_tag;
    assign ret_tag = bus.mem2proc_data_tag;

    // Force depends only on registered state and icache_req so the icache,
    // whose command reacts to icache_stall, never closes a combinational loop.
    assign force_i    = bus.icache_req && (starve_cnt >= 8'(STARVE_LIMIT));
    assign grant      = (bus.dcache_command != MEM_NONE) && !force_i;
    assign icache_sel = !grant && (bus.icache_command == MEM_LOAD);

    assign ack_nonzero   = (ack_tag != '0);
    assign load_accept   = ack_nonzero && (grant ? (bus.dcache_command == MEM_LOAD) : icache_sel);
    assign icache_accept = icache_sel && ack_nonzero;

    assign ret_live   = (ret_tag != '0) && owner_valid[ret_tag];
    assign ret_orphan = (ret_tag != '0) && !owner_valid[ret_tag];
    assign reuse_live = load_accept && owner_valid[ack_tag] && !(ret_live && (ret_tag == ack_tag));

    always_comb begin
        bus.proc2mem_command = MEM_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (grant) begin
            bus.proc2mem_command = bus.dcache_command;
            bus.proc2mem_addr    = bus.dcache_addr;
            bus.proc2mem_data    = bus.dcache_data;
        end else if (icache_sel) begin
            bus.proc2mem_command = MEM_LOAD;
            bus.proc2mem_addr    = bus.icache_addr;
        end
    end

    assign bus.dcache_grant              = grant;
    assign bus.icache_stall              = grant;
    assign bus.Dmem2proc_transaction_tag = grant      ? ack_tag : '0;
    assign bus.Imem2proc_transaction_tag = icache_sel ? ack_tag : '0;
    assign bus.Dmem2proc_data_tag        = (ret_live &&  owner_is_d[ret_tag]) ? ret_tag : '0;
    assign bus.Imem2proc_data_tag        = (ret_live && !owner_is_d[ret_tag]) ? ret_tag : '0;
    assign bus.mem2proc_data_out         = bus.mem2proc_data;
    assign bus.tag_error                 = tag_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt  <= '0;
            owner_valid <= '0;
            owner_is_d  <= '0;
            tag_error_q <= 1'b0;
        end else begin
            // Accept is written after the return clear so a same-tag reissue wins.
            if (ret_live) begin
                owner_valid[ret_tag] <= 1'b0;
            end
            if (load_accept) begin
                owner_valid[ack_tag] <= 1'b1;
                owner_is_d[ack_tag]  <= grant;
            end
            if (ret_orphan || reuse_live) begin
                tag_error_q <= 1'b1;
            end

            if (!bus.icache_req || icache_accept) begin
                starve_cnt <= '0;
            end else if (grant && (starve_cnt != 8'hFF)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end
endmodule
